// File: rtl/reg_read_stage_pkg.sv
// Shared widths, instruction field layout and decode helpers for the
// 8-bit, four-register operand-fetch stage.
package reg_read_stage_pkg;
    localparam int DATA_W   = 8;
    localparam int REG_W    = 2;
    localparam int NUM_REGS = 4;
    localparam int RS_LSB   = 4;
    localparam int RT_LSB   = 2;
    localparam int RD_LSB   = 0;
    localparam int PEND_W   = 2;
    localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;

    typedef struct packed {
        logic [1:0]       op;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } instr_t;

    // Same destination rule as the decode stage.
    function automatic logic [REG_W-1:0] dest_of(input instr_t ins, input logic regdst);
        return regdst ? ins.rd : ins.rt;
    endfunction
endpackage

// File: rtl/reg_read_stage_scoreboard.sv
// Pending-write counters, one per register, counting in-flight writers.
// Exposes "no writer left once this cycle's writeback lands" and saturation.
module reg_scoreboard
    import reg_read_stage_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Clear,
    input  logic [NUM_REGS-1:0]   i_inc,
    input  logic                  i_wb_valid,
    input  logic [REG_W-1:0]      i_wb_reg,
    output logic [NUM_REGS-1:0]   o_eff_zero,
    output logic [NUM_REGS-1:0]   o_sat
);
    logic [NUM_REGS-1:0][PEND_W-1:0] r_pend;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        logic w_dec;
        // A writeback to an idle register only updates data, never the count.
        assign w_dec = i_wb_valid && (i_wb_reg == REG_W'(g)) && (r_pend[g] != '0);
        assign o_eff_zero[g] = w_dec ? (r_pend[g] == 2'd1) : (r_pend[g] == 2'd0);
        assign o_sat[g]      = (r_pend[g] == PEND_MAX);

        always_ff @(posedge Clk) begin
            if (!Clear)
                r_pend[g] <= '0;
            else if (i_inc[g] && !w_dec)
                r_pend[g] <= r_pend[g] + 2'd1;
            else if (w_dec && !i_inc[g])
                r_pend[g] <= r_pend[g] - 2'd1;
        end
    end
endmodule

// File: rtl/reg_read_stage.sv
// Operand-fetch stage: 4x8 register file, writeback bypass, RAW/saturation
// stall via the pending-write scoreboard, and registered read outputs.
module reg_read_stage
    import reg_read_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Clear,
    input  logic              Issue_Valid,
    input  logic [7:0]        Instruction,
    input  logic              RegDst,
    input  logic              RegWrite,
    output logic              Issue_Ready,
    output logic              Read_Valid,
    output logic [DATA_W-1:0] Read_Data1,
    output logic [DATA_W-1:0] Read_Data2,
    output logic [REG_W-1:0]  Read_Dest,
    output logic              Read_RegWrite,
    input  logic              WB_Valid,
    input  logic [REG_W-1:0]  WB_Register,
    input  logic [DATA_W-1:0] WB_Data
);
    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

    instr_t                w_ins;
    logic [REG_W-1:0]      w_dest;
    logic [NUM_REGS-1:0]   w_inc;
    logic [NUM_REGS-1:0]   w_eff_zero;
    logic [NUM_REGS-1:0]   w_sat;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_rd1;
    logic [DATA_W-1:0]     w_rd2;

    assign w_ins  = instr_t'(Instruction);
    assign w_dest = dest_of(w_ins, RegDst);

    // Saturation looks at the raw count: a same-cycle writeback does not free a slot.
    assign Issue_Ready = w_eff_zero[w_ins.rs] && w_eff_zero[w_ins.rt] &&
                         !(RegWrite && w_sat[w_dest]);
    assign w_accept    = Issue_Valid && Issue_Ready;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_inc
        assign w_inc[g] = w_accept && RegWrite && (w_dest == REG_W'(g));
    end

    reg_scoreboard u_sb (
        .Clk        (Clk),
        .Clear      (Clear),
        .i_inc      (w_inc),
        .i_wb_valid (WB_Valid),
        .i_wb_reg   (WB_Register),
        .o_eff_zero (w_eff_zero),
        .o_sat      (w_sat)
    );

    assign w_rd1 = (WB_Valid && WB_Register == w_ins.rs) ? WB_Data : r_regs[w_ins.rs];
    assign w_rd2 = (WB_Valid && WB_Register == w_ins.rt) ? WB_Data : r_regs[w_ins.rt];

    always_ff @(posedge Clk) begin
        if (!Clear) begin
            r_regs <= '0;
        end else if (WB_Valid) begin
            r_regs[WB_Register] <= WB_Data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clear) begin
            Read_Valid    <= 1'b0;
            Read_Data1    <= '0;
            Read_Data2    <= '0;
            Read_Dest     <= '0;
            Read_RegWrite <= 1'b0;
        end else begin
            Read_Valid <= w_accept;
            if (w_accept) begin
                Read_Data1    <= w_rd1;
                Read_Data2    <= w_rd2;
                Read_Dest     <= w_dest;
                Read_RegWrite <= RegWrite;
            end
        end
    end
endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Operand-fetch stage of the 8-bit, four-register datapath. Holds the 4×8 register file and reads the two source fields of each issued instruction. It captures the destination field with the same RegDst rule the decode stage uses, and accepts writebacks from the end of the pipe. A per-register pending-write scoreboard stalls issue until every source operand has been written back. Same-cycle writeback data is bypassed into the read.

## Interface
Parameters:
- none (widths fixed by the shared package: data 8 bits, register index 2 bits)

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Clear  in  1  reset, synchronous, active-low
- Issue_Valid  in  1  instruction presented for issue
- Instruction  in  8  [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd
- RegDst  in  1  1: destination = Instruction[1:0]; 0: destination = Instruction[3:2]
- RegWrite  in  1  issued instruction will write its destination
- Issue_Ready  out  1  stage can accept this cycle (combinational)
- Read_Valid  out  1  one-cycle pulse, operands valid
- Read_Data1  out  8  value of rs
- Read_Data2  out  8  value of rt
- Read_Dest  out  2  captured destination index
- Read_RegWrite  out  1  captured RegWrite
- WB_Valid  in  1  writeback strobe
- WB_Register  in  2  writeback index
- WB_Data  in  8  writeback value

## Operation
- Accept = Issue_Valid & Issue_Ready.
- Scoreboard: one 2-bit pending counter per register, each counting in-flight writers.
- Effective pending: pend_eff[r] = pend[r] − (WB_Valid & WB_Register==r & pend[r]!=0).
- Issue_Ready = 1 only when all of these hold:
  - pend_eff[rs]==0;
  - pend_eff[rt]==0;
  - if RegWrite, pend[dest]!=3 (saturation stall).
- Issue_Ready ignores Issue_Valid.
- On accept, the following are registered:
  - Read_Data1 = regfile[rs], or WB_Data if WB_Valid & WB_Register==rs;
  - Read_Data2 = the same rule applied to rt;
  - Read_Dest = RegDst ? Instruction[1:0] : Instruction[3:2];
  - Read_RegWrite = RegWrite;
  - Read_Valid = 1.
- No accept: Read_Valid=0; Read_Data1/2, Read_Dest and Read_RegWrite hold their last values.
- Writeback: WB_Valid writes regfile[WB_Register]=WB_Data unconditionally.
- Counter update per register r, with inc = accept & RegWrite & dest==r and dec = WB_Valid & WB_Register==r & pend[r]!=0:
  - inc only: +1;
  - dec only: −1;
  - inc and dec together: unchanged.
- Writeback to a register with counter 0 updates data only. No underflow; the event is legal and not flagged.
- rs==rt is legal; both ports return the same value.
- Opcode bits [7:6] are ignored by this block.

## Timing
- Read latency: 1 cycle, accept at edge N gives Read_Valid high after edge N, for exactly one cycle.
- Writeback visible to a read in the same cycle (bypass) and to all later reads.
- Back-to-back issue supported, with throughput 1/cycle when there is no hazard.
- Clear low at an edge has the following effects:
  - all registers, counters, Read_Data1/2, Read_Dest and Read_RegWrite reset to 0;
  - Read_Valid resets to 0;
  - that cycle's issue and writeback are discarded;
  - Issue_Ready is 1 in the first cycle after reset.
- Issue_Ready during reset is don't-care. Upstream must not issue while Clear is low.

## Structure
- Shared package constants:
  - DATA_W=8, REG_W=2, NUM_REGS=4;
  - field positions RS_LSB=4, RT_LSB=2, RD_LSB=0;
  - PEND_MAX=3.
- Natural sub-module: `reg_scoreboard`. It contains the four pending counters and produces the per-register pend_eff / saturation flags. The top holds the regfile, bypass muxes, ready logic and output registers.

## Test plan
- Reset, then WB_Valid r2=0x5A. Issue add rs=2, rt=0 → one cycle later Read_Data1=0x5A, Read_Data2=0x00, Read_Valid pulses once.
- Issue RegWrite with RegDst=1, Instruction=0x1B → Read_Dest=3 and pend[3]=1. Next instruction with rs=3 → Issue_Ready=0 until WB_Valid r3=0x77. In that WB cycle Issue_Ready=1 and the read returns 0x77 via bypass.
- RegDst=0, Instruction=0x0C with RegWrite → Read_Dest=3. Issue three more writers to r3, with sources not r3 → the fourth (pend=3) is stalled. A single WB to r3 in the same cycle still stalls it, because the saturation check uses pend[dest], not pend_eff. Next cycle (pend=2) → accepted.
- Issue a RegWrite to r1 and WB r1 in the same cycle with pend[1]=1 → pend[1] stays 1, regfile[1] updated.
- WB to r0 with pend[0]=0 → data written, counter stays 0, no stall. Then mid-stream Clear low with pend≠0 → all outputs 0, Issue_Ready=1 afterwards, reads return 0x00.
